// File: rtl/flag_cond_unit_pkg.sv
// flag_cond_unit_pkg: condition codes, flag bit indices and shadow FSM states
package flag_cond_unit_pkg;
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHADOW = 1'b1} shadow_t;
endpackage

// File: rtl/flag_cond_unit_cond_check.sv
// cond_check: evaluates a 4-bit condition code against {C,V,N,Z} flags
module cond_check
    import flag_cond_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       pass
);
    logic c, v, n, z;
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = ~z;
            COND_CS: pass = c;
            COND_CC: pass = ~c;
            COND_MI: pass = n;
            COND_PL: pass = ~n;
            COND_VS: pass = v;
            COND_VC: pass = ~v;
            COND_HI: pass = c & ~z;
            COND_LS: pass = ~c | z;
            COND_GE: pass = n == v;
            COND_LT: pass = n != v;
            COND_GT: pass = ~z & (n == v);
            COND_LE: pass = z | (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end
endmodule

// File: rtl/flag_cond_unit.sv
// flag_cond_unit: EX/MEM result/flag register, branch condition evaluation and redirect.
// COND_PREDICATE_EN: when defined, non-branch instructions are predicated by ex_cond.
module flag_cond_unit
    import flag_cond_unit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [WIDTH-1:0]  ex_result,
    input  logic              ex_c,
    input  logic              ex_v,
    input  logic              ex_n,
    input  logic              ex_z,
    input  logic              ex_set_flags,
    input  logic              ex_is_branch,
    input  logic [3:0]        ex_cond,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [WIDTH-1:0]  mem_result,
    output logic              mem_wr_en,
    output logic [3:0]        flags_q,
    output logic              br_taken,
    output logic [ADDR_W-1:0] br_target
);
    shadow_t state, state_d;
    logic pass, live, pred_ok, taken_d, wr_en_d, flag_we;
    cond_check u_cond_check (.flags(flags_q), .cond(ex_cond), .pass(pass));
    assign live = ex_valid & ~flush & (state != ST_SHADOW);
`ifdef COND_PREDICATE_EN
    assign pred_ok = ex_is_branch | pass;
`else
    assign pred_ok = 1'b1;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end
    always_comb begin
        state_d = stall ? state : (state == ST_IDLE && taken_d) ? ST_SHADOW : ST_IDLE;
    end
    always_comb begin
        taken_d = live & ex_is_branch & pass;
        wr_en_d = live & ~ex_is_branch & pred_ok;
        flag_we = live & ex_set_flags & pred_ok;
    end
    // Flags update after the branch was evaluated against the old flags_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid  <= 1'b0;
            mem_result <= '0;
            mem_wr_en  <= 1'b0;
            flags_q    <= 4'b0000;
            br_taken   <= 1'b0;
            br_target  <= '0;
        end else if (stall) begin
            br_taken <= 1'b0;
        end else begin
            mem_valid  <= live;
            mem_result <= ex_result;
            mem_wr_en  <= wr_en_d;
            br_taken   <= taken_d;
            if (taken_d) br_target <= ex_target;
            if (flag_we) flags_q <= {ex_c, ex_v, ex_n, ex_z};
        end
    end
endmodule

// File: tb/tb_flag_cond_unit.sv
// tb_flag_cond_unit: scoreboard bench with directed and random stimulus against a reference model.
module tb_flag_cond_unit;
    typedef struct packed {
        logic        mv;
        logic [15:0] mr;
        logic        we;
        logic [3:0]  fl;
        logic        bt;
        logic [15:0] btg;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ex_valid = 1'b0, ex_c = 1'b0, ex_v = 1'b0, ex_n = 1'b0, ex_z = 1'b0;
    logic ex_set_flags = 1'b0, ex_is_branch = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [15:0] ex_result = '0, ex_target = '0;
    logic [3:0] ex_cond = '0;
    logic mem_valid, mem_wr_en, br_taken;
    logic [15:0] mem_result, br_target;
    logic [3:0] flags_q;
    exp_t q[$];
    exp_t m = '0;
    bit squash = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    flag_cond_unit #(.WIDTH(16), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_c(ex_c), .ex_v(ex_v), .ex_n(ex_n), .ex_z(ex_z),
        .ex_set_flags(ex_set_flags), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
        .ex_target(ex_target), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_wr_en(mem_wr_en),
        .flags_q(flags_q), .br_taken(br_taken), .br_target(br_target)
    );
    // Conditions come in complementary pairs: odd code = inverse of the even one.
    function automatic bit cond_ok(logic [3:0] f, logic [3:0] cd);
        bit c = f[3], v = f[2], n = f[1], z = f[0];
        bit base;
        case (cd[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cd[0];
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, req, $time);
        end
    endtask
    task automatic drive(bit r, bit v, logic [15:0] res, logic [3:0] f, bit sf, bit br,
                         logic [3:0] cd, logic [15:0] tg, bit st, bit fl);
        bit live, ok, pred;
        @(negedge clk);
        rst_n = r; ex_valid = v; ex_result = res; {ex_c, ex_v, ex_n, ex_z} = f;
        ex_set_flags = sf; ex_is_branch = br; ex_cond = cd; ex_target = tg;
        stall = st; flush = fl;
        if (!r) begin
            m = '0;
            squash = 1'b0;
        end else if (st) begin
            m.bt = 1'b0;
        end else begin
            live = v && !fl && !squash;
            ok = cond_ok(m.fl, cd);
`ifdef COND_PREDICATE_EN
            pred = br || ok;
`else
            pred = 1'b1;
`endif
            m.mv = live;
            m.mr = res;
            m.we = live && !br && pred;
            m.bt = live && br && ok;
            if (m.bt) m.btg = tg;
            if (live && sf && pred) m.fl = f;
            squash = m.bt;
        end
        q.push_back(m);
    endtask
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("mem_valid", 32'(mem_valid), 32'(e.mv));
            chk("mem_result", 32'(mem_result), 32'(e.mr));
            chk("mem_wr_en", 32'(mem_wr_en), 32'(e.we));
            chk("flags_q", 32'(flags_q), 32'(e.fl));
            chk("br_taken", 32'(br_taken), 32'(e.bt));
            chk("br_target", 32'(br_target), 32'(e.btg));
        end
    end
    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 16'h1111, 4'b0000, 0, 0, 4'hE, 0, 0, 0);
        drive(0, 1, 16'h2222, 4'b1111, 1, 1, 4'hE, 16'h0BAD, 0, 0);
        drive(0, 1, 16'h3333, 4'b1111, 1, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h4444, 4'b0000, 0, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h0000, 4'b1001, 1, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h5555, 4'b0000, 0, 1, 4'h0, 16'h0040, 0, 0);
        drive(1, 1, 16'h6666, 4'b0000, 1, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h7777, 4'b0000, 0, 0, 4'h1, 0, 0, 0);
        drive(1, 1, 16'h0001, 4'b0100, 1, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h0002, 4'b0000, 0, 1, 4'hB, 16'h0080, 0, 0);
        drive(1, 1, 16'h0003, 4'b0000, 0, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h0004, 4'b0000, 0, 1, 4'hA, 16'h00C0, 0, 0);
        drive(1, 1, 16'h0005, 4'b1111, 1, 0, 4'hE, 0, 1, 1);
        drive(1, 1, 16'h0005, 4'b1111, 1, 0, 4'hE, 0, 0, 1);
        drive(1, 1, 16'h0006, 4'b0000, 0, 1, 4'h2, 16'h0100, 1, 0);
        drive(1, 1, 16'h0006, 4'b0100, 0, 1, 4'hA, 16'h0100, 0, 0);
        drive(1, 1, 16'h0007, 4'b0000, 0, 1, 4'hB, 16'h0200, 1, 0);
        drive(1, 1, 16'h0007, 4'b0000, 0, 1, 4'hB, 16'h0200, 1, 0);
        drive(1, 1, 16'h0007, 4'b0000, 0, 1, 4'hB, 16'h0200, 0, 0);
        drive(1, 1, 16'h0008, 4'b0000, 1, 0, 4'hE, 0, 1, 0);
        drive(1, 1, 16'h0008, 4'b0000, 1, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h0009, 4'b0001, 1, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h000A, 4'b0000, 1, 0, 4'h1, 0, 0, 0);
        drive(1, 1, 16'h000B, 4'b0000, 1, 1, 4'h0, 16'h0300, 0, 0);
        drive(1, 1, 16'h000C, 4'b0000, 0, 0, 4'hE, 0, 0, 0);
        drive(1, 1, 16'h000D, 4'b0000, 0, 1, 4'h0, 16'h0400, 0, 0);
        for (int i = 0; i < 600; i++)
            drive($urandom_range(0, 59) != 0, $urandom_range(0, 3) != 0, 16'($urandom),
                  4'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 4'($urandom),
                  16'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
        @(posedge clk);
        #3;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
